// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the 10-bit CPU memory stage.
// Stalls the EX/MEM register via cache_Ready while a line fill or store is outstanding to RAM.
module dcache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [9:0] cpu_wdata,
  output logic [9:0] cpu_rdata,
  output logic       cache_Ready,
  output logic       ram_req,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [9:0] ram_wdata,
  input  logic [9:0] ram_rdata,
  input  logic       ram_ack
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 10 - INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESUME} state_t;

  state_t             state_q, state_d;
  logic [9:0]         rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [9:0]         addr_q, addr_d;
  logic [9:0]         wdata_q, wdata_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [9:0]         data_q [LINES];

  logic [9:0]         lk_addr;
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               hit;
  logic               line_we;
  logic [9:0]         line_data;

  // While a RAM op is outstanding, look up the latched request address, not the live bus.
  assign lk_addr = (state_q == IDLE) ? cpu_addr : addr_q;
  assign lk_idx  = lk_addr[INDEX_W-1:0];
  assign lk_tag  = lk_addr[9:INDEX_W];
  assign hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    valid_d   = valid_q;
    line_we   = 1'b0;
    line_data = ram_rdata;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = WRITE;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            ready_d = 1'b0;
          end else if (hit) begin
            rdata_d = data_q[lk_idx];
          end else begin
            state_d = FILL;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = cpu_addr;
            ready_d = 1'b0;
          end
        end
      end
      FILL: begin
        if (ram_ack) begin
          valid_d[lk_idx] = 1'b1;
          line_we         = 1'b1;
          line_data       = ram_rdata;
          rdata_d         = ram_rdata;
          req_d           = 1'b0;
          ready_d         = 1'b1;
          state_d         = RESUME;
        end
      end
      WRITE: begin
        if (ram_ack) begin
          line_we   = hit;
          line_data = wdata_q;
          req_d     = 1'b0;
          we_d      = 1'b0;
          ready_d   = 1'b1;
          state_d   = RESUME;
        end
      end
      RESUME: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[lk_idx]  <= lk_tag;
      data_q[lk_idx] <= line_data;
    end
  end

  assign cpu_rdata   = rdata_q;
  assign cache_Ready = ready_q;
  assign ram_req     = req_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Table-driven check of dcache_ctrl against a behavioural RAM that acks after a set delay.
module tb_dcache_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cache_Ready, ram_req, ram_we;
  logic [9:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_ack;

  dcache_ctrl #(.INDEX_W(3)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cache_Ready(cache_Ready), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM model: acks ack_dly negedges after ram_req is first seen.
  int         ack_dly = 1;
  logic [9:0] fill_val = '0;
  int         cnt = 0;
  int         n_req = 0;
  logic       inject = 1'b0;
  logic       unstable = 1'b0;
  logic       cap_we;
  logic [9:0] cap_addr, cap_wdata;

  always @(negedge clk) begin
    ram_ack = inject;
    if (ram_req) begin
      cnt++;
      if (cnt == 1) begin
        n_req++;
        cap_we = ram_we; cap_addr = ram_addr; cap_wdata = ram_wdata;
      end else if (ram_we !== cap_we || ram_addr !== cap_addr || ram_wdata !== cap_wdata) begin
        unstable = 1'b1;
      end
      if (cnt == ack_dly) begin
        ram_ack   = 1'b1;
        ram_rdata = fill_val;
      end
    end else begin
      cnt = 0;
    end
  end

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [9:0] wdata;
    logic [9:0] fill;
    int         dly;
    logic       chk_rd;
    logic [9:0] exp_rd;
    int         exp_stall;
    int         exp_req;
    logic       hold;
  } vec_t;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [9:0] wdata;
    logic       chk_rd;
    logic [9:0] exp_rd;
    int         exp_stall;
    int         exp_req;
  } exp_t;

  exp_t sb[$];

  task automatic do_op(input vec_t v, input string tag);
    int   req0, stall;
    bit   done;
    exp_t e;
    ack_dly  = v.dly;
    fill_val = v.fill;
    req0     = n_req;
    unstable = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    sb.push_back('{v.we, v.addr, v.wdata, v.chk_rd, v.exp_rd, v.exp_stall, v.exp_req});
    stall = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!cache_Ready) stall++;
      else done = 1'b1;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({tag, " timeout"}, 0, 1);
      cpu_req = 1'b0;
      return;
    end
    chk({tag, " stall"}, stall, e.exp_stall);
    chk({tag, " nreq"}, n_req - req0, e.exp_req);
    if (e.chk_rd) chk({tag, " rdata"}, cpu_rdata, e.exp_rd);
    if (e.exp_req == 1) begin
      chk({tag, " ram_we"}, cap_we, e.we);
      chk({tag, " ram_addr"}, cap_addr, e.addr);
      if (e.we) chk({tag, " ram_wdata"}, cap_wdata, e.wdata);
      chk({tag, " stable"}, unstable, 0);
    end
    if (v.hold) begin
      // Request held through RESUME must not be re-issued.
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      chk({tag, " resume_noreq"}, ram_req, 0);
      chk({tag, " resume_nreq"}, n_req - req0, e.exp_req);
    end else begin
      cpu_req = 1'b0;
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 10'h005, 10'h000, 10'h111, 1, 1'b1, 10'h111, 1, 1, 1'b0};
    tbl[1]  = '{1'b0, 10'h00D, 10'h000, 10'h2A5, 2, 1'b1, 10'h2A5, 2, 1, 1'b0};
    tbl[2]  = '{1'b0, 10'h00D, 10'h000, 10'h000, 1, 1'b1, 10'h2A5, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 10'h015, 10'h000, 10'h0F0, 1, 1'b1, 10'h0F0, 1, 1, 1'b0};
    tbl[4]  = '{1'b0, 10'h00D, 10'h000, 10'h2A5, 3, 1'b1, 10'h2A5, 3, 1, 1'b0};
    tbl[5]  = '{1'b1, 10'h00D, 10'h13C, 10'h000, 2, 1'b0, 10'h000, 2, 1, 1'b0};
    tbl[6]  = '{1'b0, 10'h00D, 10'h000, 10'h000, 1, 1'b1, 10'h13C, 0, 0, 1'b0};
    tbl[7]  = '{1'b1, 10'h3F0, 10'h3FF, 10'h000, 1, 1'b0, 10'h000, 1, 1, 1'b0};
    tbl[8]  = '{1'b0, 10'h3F0, 10'h000, 10'h3FF, 1, 1'b1, 10'h3FF, 1, 1, 1'b0};
    tbl[9]  = '{1'b1, 10'h3F0, 10'h155, 10'h000, 1, 1'b0, 10'h000, 1, 1, 1'b1};
    tbl[10] = '{1'b0, 10'h3F0, 10'h000, 10'h000, 1, 1'b1, 10'h155, 0, 0, 1'b0};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst ready", cache_Ready, 1);
    chk("rst ram_req", ram_req, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    reset = 1'b0;

    // Reset asserted mid-FILL abandons the request asynchronously.
    ack_dly = 50;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    @(posedge clk);
    #2;
    chk("midfill ram_req", ram_req, 1);
    chk("midfill ready", cache_Ready, 0);
    reset = 1'b1;
    #1;
    chk("async ram_req", ram_req, 0);
    chk("async ready", cache_Ready, 1);
    chk("async ram_addr", ram_addr, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // Stray ack while idle must be ignored.
    @(negedge clk);
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    chk("idle_ack ram_req", ram_req, 0);
    chk("idle_ack ready", cache_Ready, 1);
    do_op(tbl[10], "after_idle_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
